// File: rtl/aes_pkg.sv
// Shared widths and loader state encoding for the AES input loader slice.
package aes_pkg;

   localparam int unsigned AES_BLK_W  = 128;
   localparam int unsigned AES_WORD_W = 32;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      RUN  = 2'd1,
      GAP  = 2'd2
   } aes_ld_state_t;

endpackage

// File: rtl/aes_word_assembler.sv
// Shifts four 32-bit words (MSW first) into a 128-bit register and flags it full.
module aes_word_assembler
   import aes_pkg::*;
(
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_wr,
   input  logic                  i_clr,
   input  logic [AES_WORD_W-1:0] i_word,
   output logic [AES_BLK_W-1:0]  o_blk,
   output logic                  o_full
);

   logic [AES_BLK_W-1:0] r_blk;
   logic [1:0]           r_cnt;
   logic                 r_full;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_blk  <= '0;
         r_cnt  <= '0;
         r_full <= 1'b0;
      end else if (i_clr) begin
         r_cnt  <= '0;
         r_full <= 1'b0;
      end else if (i_wr) begin
         r_blk <= {r_blk[AES_BLK_W-AES_WORD_W-1:0], i_word};
         r_cnt <= r_cnt + 2'd1;
         // First word of a new sequence invalidates the previous contents
         if (r_cnt == 2'd3)
            r_full <= 1'b1;
         else if (r_cnt == 2'd0)
            r_full <= 1'b0;
      end
   end

   assign o_blk  = r_blk;
   assign o_full = r_full;

endmodule

// File: rtl/aes_in_loader.sv
// Collects key/plaintext words, then holds them stable while enabling the AES core.
module aes_in_loader
   import aes_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic                  AES_clk,
   input  logic                  AES_rst,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [AES_WORD_W-1:0] wr_data,
   input  logic                  wr_is_key,
   output logic                  AES_en,
   output logic [AES_BLK_W-1:0]  AES_data_in,
   output logic [AES_BLK_W-1:0]  AES_key_in,
   input  logic                  AES_data_out_valid,
   output logic                  busy,
   output logic                  timeout_err
);

   localparam int unsigned RUN_W = $clog2(TIMEOUT_CYC);

   aes_ld_state_t    r_state;
   logic [RUN_W-1:0] r_run_cnt;
   logic             r_timeout_err;

   logic w_accept;
   logic w_key_full;
   logic w_data_full;
   logic w_clr_data;

   assign wr_ready   = (r_state == LOAD) && (wr_is_key || !w_data_full);
   assign w_accept   = wr_valid && wr_ready;
   assign w_clr_data = (r_state == GAP);

   aes_word_assembler u_key (
      .i_clk  (AES_clk),
      .i_rst  (AES_rst),
      .i_wr   (w_accept && wr_is_key),
      .i_clr  (1'b0),
      .i_word (wr_data),
      .o_blk  (AES_key_in),
      .o_full (w_key_full)
   );

   aes_word_assembler u_data (
      .i_clk  (AES_clk),
      .i_rst  (AES_rst),
      .i_wr   (w_accept && !wr_is_key),
      .i_clr  (w_clr_data),
      .i_word (wr_data),
      .o_blk  (AES_data_in),
      .o_full (w_data_full)
   );

   always_ff @(posedge AES_clk or posedge AES_rst) begin
      if (AES_rst) begin
         r_state       <= LOAD;
         r_run_cnt     <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_timeout_err <= 1'b0;
         case (r_state)
            LOAD: begin
               if (w_data_full && w_key_full) begin
                  r_state   <= RUN;
                  r_run_cnt <= '0;
               end
            end
            RUN: begin
               r_run_cnt <= r_run_cnt + RUN_W'(1);
               // Completion takes priority over a coincident timeout
               if (AES_data_out_valid) begin
                  r_state <= GAP;
               end else if (r_run_cnt == RUN_W'(TIMEOUT_CYC - 1)) begin
                  r_state       <= GAP;
                  r_timeout_err <= 1'b1;
               end
            end
            GAP:     r_state <= LOAD;
            default: r_state <= LOAD;
         endcase
      end
   end

   assign AES_en      = (r_state == RUN);
   assign busy        = (r_state == RUN) || (r_state == GAP);
   assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_aes_in_loader.sv
// Directed bench for aes_in_loader: launch, completion, back-to-back, timeout, blocking, reset.
module tb_aes_in_loader;

   logic         AES_clk = 1'b0;
   logic         AES_rst = 1'b1;
   logic         wr_valid = 1'b0;
   logic         wr_ready;
   logic [31:0]  wr_data = '0;
   logic         wr_is_key = 1'b0;
   logic         AES_en;
   logic [127:0] AES_data_in;
   logic [127:0] AES_key_in;
   logic         AES_data_out_valid = 1'b0;
   logic         busy;
   logic         timeout_err;

   int n_err = 0;
   int n_chk = 0;
   int n;

   aes_in_loader #(.TIMEOUT_CYC(64)) dut (
      .AES_clk            (AES_clk),
      .AES_rst            (AES_rst),
      .wr_valid           (wr_valid),
      .wr_ready           (wr_ready),
      .wr_data            (wr_data),
      .wr_is_key          (wr_is_key),
      .AES_en             (AES_en),
      .AES_data_in        (AES_data_in),
      .AES_key_in         (AES_key_in),
      .AES_data_out_valid (AES_data_out_valid),
      .busy               (busy),
      .timeout_err        (timeout_err)
   );

   always #5 AES_clk = ~AES_clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One accepted word per call; entered and left at posedge+1
   task automatic put(input logic k, input logic [31:0] d);
      wr_valid  = 1'b1;
      wr_is_key = k;
      wr_data   = d;
      @(posedge AES_clk); #1;
      wr_valid  = 1'b0;
      wr_is_key = 1'b0;
   endtask

   // Called in the first RUN cycle; returns the number of cycles AES_en was high
   task automatic run_measure(input int valid_at, output int cyc);
      cyc = 1;
      for (int i = 0; i < 300; i++) begin
         if (cyc == valid_at) AES_data_out_valid = 1'b1;
         @(posedge AES_clk); #1;
         AES_data_out_valid = 1'b0;
         if (!AES_en) break;
         cyc++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) @(posedge AES_clk);
      #1 AES_rst = 1'b0;
      check("rst_en",    AES_en, 0);
      check("rst_ready", wr_ready, 1);
      check("rst_busy",  busy, 0);
      check("rst_terr",  timeout_err, 0);
      check("rst_data",  AES_data_in, 0);
      check("rst_key",   AES_key_in, 0);

      // Valid outside RUN has no effect
      AES_data_out_valid = 1'b1;
      @(posedge AES_clk); #1;
      AES_data_out_valid = 1'b0;
      check("idle_valid_busy", busy, 0);

      // Basic launch
      put(1, 32'haa2bdb40); put(1, 32'hbff6a5e8); put(1, 32'hcaa9ba3e); put(1, 32'hbc1e2acc);
      put(0, 32'h000000cf); put(0, 32'h0); put(0, 32'h0); put(0, 32'h0);
      check("basic_key",  AES_key_in, 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc);
      check("basic_data", AES_data_in, 128'h000000cf_00000000_00000000_00000000);
      check("basic_en_pre", AES_en, 0);
      @(posedge AES_clk); #1;
      check("basic_en_rise", AES_en, 1);
      check("basic_busy", busy, 1);
      wr_is_key = 1'b1;
      #1 check("run_ready_key", wr_ready, 0);
      wr_is_key = 1'b0;
      #1 check("run_ready_data", wr_ready, 0);

      // Completion after 10 cycles: AES_en high for 11
      run_measure(11, n);
      check("cmpl_len", n, 11);
      check("gap_en", AES_en, 0);
      check("gap_busy", busy, 1);
      check("gap_terr", timeout_err, 0);
      check("gap_keyfull", dut.w_key_full, 1);
      @(posedge AES_clk); #1;
      check("load_busy", busy, 0);
      check("load_ready", wr_ready, 1);

      // Back-to-back with retained key
      put(0, 32'ha6f2daeb); put(0, 32'h140fa720); put(0, 32'h529e75d5); put(0, 32'h21cbc681);
      check("b2b_data", AES_data_in, 128'ha6f2daeb_140fa720_529e75d5_21cbc681);
      @(posedge AES_clk); #1;
      check("b2b_en", AES_en, 1);
      check("b2b_key", AES_key_in, 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc);
      run_measure(3, n);
      check("b2b_len", n, 3);
      @(posedge AES_clk); #1;

      // Timeout
      put(0, 32'h1); put(0, 32'h2); put(0, 32'h3); put(0, 32'h4);
      @(posedge AES_clk); #1;
      check("to_en", AES_en, 1);
      run_measure(0, n);
      check("to_len", n, 64);
      check("to_terr", timeout_err, 1);
      @(posedge AES_clk); #1;
      check("to_terr_off", timeout_err, 0);
      check("to_load", busy, 0);

      // Valid in the 64th cycle beats the timeout
      put(0, 32'h5); put(0, 32'h6); put(0, 32'h7); put(0, 32'h8);
      @(posedge AES_clk); #1;
      run_measure(64, n);
      check("v64_len", n, 64);
      check("v64_terr", timeout_err, 0);
      @(posedge AES_clk); #1;

      // Blocked data word while key only half loaded
      put(1, 32'h11111111); put(1, 32'h22222222);
      put(0, 32'h5); put(0, 32'h6); put(0, 32'h7); put(0, 32'h8);
      wr_valid = 1'b1; wr_is_key = 1'b0; wr_data = 32'hdeadbeef;
      #1 check("blk_ready_data", wr_ready, 0);
      wr_is_key = 1'b1;
      #1 check("blk_ready_key", wr_ready, 1);
      wr_valid = 1'b0; wr_is_key = 1'b0;
      repeat (2) @(posedge AES_clk);
      #1 check("blk_no_launch", AES_en, 0);
      check("blk_data_kept", AES_data_in, 128'h00000005_00000006_00000007_00000008);
      put(1, 32'h33333333);
      check("blk_3key_en", AES_en, 0);
      put(1, 32'h44444444);
      check("blk_4key_en", AES_en, 0);
      @(posedge AES_clk); #1;
      check("blk_launch", AES_en, 1);
      check("blk_key", AES_key_in, 128'haa2bdb40_bff6a5e8_11111111_22222222 << 64 | 128'h33333333_44444444);
      run_measure(5, n);
      check("blk_len", n, 5);
      @(posedge AES_clk); #1;

      // Reset in the middle of RUN
      put(0, 32'h9); put(0, 32'ha); put(0, 32'hb); put(0, 32'hc);
      @(posedge AES_clk); #1;
      check("mr_en", AES_en, 1);
      repeat (4) @(posedge AES_clk);
      #2 AES_rst = 1'b1;
      #1;
      check("mr_en_drop", AES_en, 0);
      check("mr_busy", busy, 0);
      check("mr_ready", wr_ready, 1);
      check("mr_terr", timeout_err, 0);
      check("mr_data", AES_data_in, 0);
      check("mr_key", AES_key_in, 0);
      @(posedge AES_clk); #1 AES_rst = 1'b0;
      put(0, 32'hd); put(0, 32'he); put(0, 32'hf); put(0, 32'h10);
      repeat (3) @(posedge AES_clk);
      #1 check("mr_no_launch", AES_en, 0);
      put(1, 32'h01020304); put(1, 32'h05060708); put(1, 32'h090a0b0c); put(1, 32'h0d0e0f10);
      @(posedge AES_clk); #1;
      check("mr_relaunch", AES_en, 1);
      check("mr_new_key", AES_key_in, 128'h01020304_05060708_090a0b0c_0d0e0f10);
      run_measure(2, n);
      check("mr_len", n, 2);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
